// File: rtl/instr_encoder_loader_if.sv
// Handshake and memory-write bundle between an instruction source and the loader.
// The master drives session control and instruction fields; the slave returns strobes and status.
interface instr_encoder_loader_if;
  logic        Start;
  logic [31:0] BaseAddr;
  logic        Stop;
  logic        InValid;
  logic        InReady;
  logic [3:0]  Op;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [15:0] Imm;
  logic [25:0] Target;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic [7:0]  Count;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport master (
    output Start, BaseAddr, Stop, InValid, Op, Rs, Rt, Rd, Imm, Target,
    input  InReady, MemWrite, MemAddr, MemData, Count, Busy, Done, Error
  );

  modport slave (
    input  Start, BaseAddr, Stop, InValid, Op, Rs, Rt, Rd, Imm, Target,
    output InReady, MemWrite, MemAddr, MemData, Count, Busy, Done, Error
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes MIPS-style instruction fields into 32-bit words and writes them
// to consecutive instruction-memory addresses, one word per two cycles.
module instr_encoder_loader (
  input  logic                          clk,
  input  logic                          rst_n,
  instr_encoder_loader_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  count_q, count_d;
  logic        error_q, error_d;
  logic        stop_q, stop_d;
  logic        mem_write_q, mem_write_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        accept_s;

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    case (op)
      4'd0:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    encode = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    encode = {6'b001000, rs, rt, imm};
      4'd6:    encode = {6'b001101, rs, rt, imm};
      4'd7:    encode = {6'b001100, rs, rt, imm};
      4'd8:    encode = {6'b001010, rs, rt, imm};
      4'd9:    encode = {6'b100011, rs, rt, imm};
      4'd10:   encode = {6'b101011, rs, rt, imm};
      4'd11:   encode = {6'b000100, rs, rt, imm};
      4'd12:   encode = {6'b000101, rs, rt, imm};
      4'd13:   encode = {6'b000111, rs, 5'b00000, imm};
      4'd14:   encode = {6'b000010, tgt};
      default: encode = 32'h0000_0000;
    endcase
  endfunction

  assign accept_s = (state_q == RUN) && bus.InValid && in_ready_q;

  // Next-state and datapath updates; status outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    error_d = error_q;
    stop_d  = stop_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          addr_d  = bus.BaseAddr & 32'hFFFF_FFFC;
          count_d = 8'd0;
          error_d = 1'b0;
          stop_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          if (bus.Op == 4'd15) begin
            error_d = 1'b1;
            state_d = bus.Stop ? DONE : RUN;
          end else begin
            data_d  = encode(bus.Op, bus.Rs, bus.Rt, bus.Rd, bus.Imm, bus.Target);
            stop_d  = bus.Stop;
            state_d = WRITE;
          end
        end else if (bus.Stop) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 32'd4;
        count_d = count_q + 8'd1;
        stop_d  = 1'b0;
        // A Stop seen during the write cycle is honoured just like a latched one.
        if (stop_q || bus.Stop || (count_q == 8'd254)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        stop_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        stop_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    mem_write_d = (state_d == WRITE);
    in_ready_d  = (state_d == RUN);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      data_q      <= 32'h0000_0000;
      count_q     <= 8'd0;
      error_q     <= 1'b0;
      stop_q      <= 1'b0;
      mem_write_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      count_q     <= count_d;
      error_q     <= error_d;
      stop_q      <= stop_d;
      mem_write_q <= mem_write_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.MemWrite = mem_write_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemData  = data_q;
  assign bus.Count    = count_q;
  assign bus.Error    = error_q;
  assign bus.InReady  = in_ready_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a reference model predicts every
// memory write, and a negedge monitor pops and compares each strobe.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_loader_if bus ();

  instr_encoder_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;
  int  pass_cnt = 0;
  int  chk_cnt  = 0;

  logic [31:0] exp_addr;
  logic [7:0]  exp_count;
  logic        exp_err;

  localparam int unsigned OPC [15] = '{0, 0, 0, 0, 0, 8, 13, 12, 10, 35, 43, 4, 5, 7, 2};
  localparam int unsigned FN  [5]  = '{32, 34, 36, 37, 42};

  function automatic logic [31:0] ref_word(input int unsigned op, input int unsigned rs,
                                           input int unsigned rt, input int unsigned rd,
                                           input int unsigned imm, input int unsigned tgt);
    int unsigned w;
    if (op < 5) w = rs * 2097152 + rt * 65536 + rd * 2048 + FN[op];
    else if (op == 14) w = 2 * 67108864 + tgt;
    else if (op == 13) w = OPC[op] * 67108864 + rs * 2097152 + imm;
    else w = OPC[op] * 67108864 + rs * 2097152 + rt * 65536 + imm;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (rst_n && bus.MemWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.MemAddr, bus.MemData);
      end else begin
        mon_w = exp_q.pop_front();
        check("mem_addr", bus.MemAddr, mon_w.a);
        check("mem_data", bus.MemData, mon_w.d);
      end
    end
  end

  task automatic start(input logic [31:0] base);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.BaseAddr = base;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    exp_addr = {base[31:2], 2'b00};
    exp_count = 8'd0;
    exp_err = 1'b0;
    @(negedge clk);
    check("start_busy", {31'd0, bus.Busy}, 32'd1);
    check("start_ready", {31'd0, bus.InReady}, 32'd1);
    check("start_addr", bus.MemAddr, exp_addr);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit stop, input bit use_lit, input logic [31:0] lit);
    bit ok = 1'b0;
    @(negedge clk);
    bus.Op = op; bus.Rs = rs; bus.Rt = rt; bus.Rd = rd; bus.Imm = imm; bus.Target = tgt;
    bus.InValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.InReady === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk_cnt++;
      $display("FAIL ready_timeout: got InReady 0 for 20 cycles expected 1");
      bus.InValid = 1'b0;
      return;
    end
    bus.Stop = stop;
    if (op == 4'd15) begin
      exp_err = 1'b1;
    end else begin
      exp_q.push_back({exp_addr, use_lit ? lit : ref_word(op, rs, rt, rd, imm, tgt)});
      exp_addr = exp_addr + 32'd4;
      exp_count = exp_count + 8'd1;
    end
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    bus.Stop = 1'b0;
  endtask

  task automatic send_rand(input bit allow_illegal);
    logic [3:0] op;
    op = allow_illegal ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 14));
    send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
         1'b0, 1'b0, 32'd0);
  endtask

  task automatic settle_count();
    repeat (2) @(negedge clk);
    check("count", {24'd0, bus.Count}, {24'd0, exp_count});
    check("addr_after", bus.MemAddr, exp_addr);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_pulse", {31'd0, seen}, 32'd1);
    check("done_busy", {31'd0, bus.Busy}, 32'd1);
    check("done_ready", {31'd0, bus.InReady}, 32'd0);
  endtask

  task automatic stop_session();
    @(negedge clk);
    bus.Stop = 1'b1;
    @(posedge clk);
    #1;
    bus.Stop = 1'b0;
    wait_done();
    @(negedge clk);
    check("idle_done", {31'd0, bus.Done}, 32'd0);
    check("idle_busy", {31'd0, bus.Busy}, 32'd0);
  endtask

  initial begin
    bus.Start = 1'b0; bus.BaseAddr = 32'd0; bus.Stop = 1'b0; bus.InValid = 1'b0;
    bus.Op = 4'd0; bus.Rs = 5'd0; bus.Rt = 5'd0; bus.Rd = 5'd0; bus.Imm = 16'd0; bus.Target = 26'd0;
    exp_addr = 32'd0; exp_count = 8'd0; exp_err = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    check("rst_count", {24'd0, bus.Count}, 32'd0);
    check("rst_addr", bus.MemAddr, 32'd0);
    check("rst_data", bus.MemData, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single addi: strobe in the cycle after acceptance, count advances after the write.
    start(32'h0040_0000);
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'hFFFF, 26'd0, 1'b0, 1'b1, 32'h2008_FFFF);
    check("latency_memwrite", {31'd0, bus.MemWrite}, 32'd1);
    settle_count();
    check("count_one", {24'd0, bus.Count}, 32'd1);
    stop_session();

    // add then j, then bgtz, illegal op, Start-in-RUN, and sw with Stop.
    start(32'h0040_0000);
    send(4'd0, 5'd9, 5'd10, 5'd8, 16'd0, 26'd0, 1'b0, 1'b1, 32'h012A_4020);
    send(4'd14, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000, 1'b0, 1'b1, 32'h0810_0000);
    send(4'd13, 5'd4, 5'd7, 5'd0, 16'd3, 26'd0, 1'b0, 1'b1, 32'h1C80_0003);
    send(4'd15, 5'd1, 5'd2, 5'd3, 16'd4, 26'd5, 1'b0, 1'b0, 32'd0);
    settle_count();
    check("illegal_error", {31'd0, bus.Error}, 32'd1);
    check("illegal_ready", {31'd0, bus.InReady}, 32'd1);
    @(negedge clk);
    bus.Start = 1'b1; bus.BaseAddr = 32'h0000_1000;
    @(negedge clk);
    bus.Start = 1'b0;
    send_rand(1'b0);
    send(4'd10, 5'd29, 5'd31, 5'd0, 16'd0, 26'd0, 1'b1, 1'b1, 32'hAFBF_0000);
    @(negedge clk);
    wait_done();
    @(negedge clk);
    check("sw_idle_busy", {31'd0, bus.Busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("hold_count", {24'd0, bus.Count}, {24'd0, exp_count});
    check("hold_error", {31'd0, bus.Error}, {31'd0, exp_err});
    check("hold_addr", bus.MemAddr, exp_addr);

    // Random session with occasional illegal ops.
    start($urandom);
    for (int i = 0; i < 30; i++) send_rand(1'b1);
    stop_session();
    check("rand_count", {24'd0, bus.Count}, {24'd0, exp_count});
    check("rand_error", {31'd0, bus.Error}, {31'd0, exp_err});
    check("rand_addr", bus.MemAddr, exp_addr);

    // 255 back-to-back writes with address wrap past 2^32.
    start(32'hFFFF_FE03);
    for (int i = 0; i < 255; i++) send_rand(1'b0);
    wait_done();
    check("full_count", {24'd0, bus.Count}, 32'd255);
    @(negedge clk);
    bus.InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_ready_low", {31'd0, bus.InReady}, 32'd0);
    end
    bus.InValid = 1'b0;
    check("full_idle", {31'd0, bus.Busy}, 32'd0);
    check("full_addr", bus.MemAddr, exp_addr);

    // Reset during WRITE aborts the strobe.
    start(32'h0000_0100);
    send_rand(1'b0);
    check("pre_rst_memwrite", {31'd0, bus.MemWrite}, 32'd1);
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    #1;
    check("arst_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("arst_count", {24'd0, bus.Count}, 32'd0);
    check("arst_addr", bus.MemAddr, 32'd0);
    check("arst_data", bus.MemData, 32'd0);
    check("arst_ready", {31'd0, bus.InReady}, 32'd0);
    check("arst_done", {31'd0, bus.Done}, 32'd0);
    check("arst_error", {31'd0, bus.Error}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_count", {24'd0, bus.Count}, 32'd0);
    check("post_rst_busy", {31'd0, bus.Busy}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
